if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/pipe_pkg.sv | 11 +
 rtl/if_id_queue.sv | 125 ++++++++++++
 tb/tb_if_id_queue.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types used by the fetch and decode stages.
package pipe_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode packet queue with a valid/ready handshake on both sides.
// The optional stall/bubble performance counters are enabled by defining
// IF_ID_PERF_CNT_EN. Without it, both counter ports read as 0.
module if_id_queue
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            f_valid,
    input  logic [XLEN-1:0] f_pc,
    input  logic [XLEN-1:0] f_instr,
    output logic            f_ready,
    output logic            d_valid,
    output logic [XLEN-1:0] d_pc,
    output logic [XLEN-1:0] d_instr,
    input  logic            d_ready,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     bubble_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    fetch_pkt_t      mem_q [DEPTH];
    fetch_pkt_t      mem_d [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;
    fetch_pkt_t      head;

    // Handshake outputs depend only on registered state, so there is no
    // combinational path from d_ready to f_ready and no empty-queue bypass.
    always_comb begin
        f_ready = (count_q < DepthC);
        d_valid = (count_q != '0);
        head    = mem_q[rptr_q];
        d_pc    = head.pc;
        d_instr = head.instr;
        push    = f_valid && f_ready && !flush;
        pop     = d_valid && d_ready && !flush;
    end

    // Next-state for storage, pointers and occupancy; flush overrides everything.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = '{pc: f_pc, instr: f_instr};
                wptr_d        = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state register; storage is cleared on reset so d_pc/d_instr read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; deliberately unaffected by flush.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (f_valid && !f_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (d_ready && !d_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=2).
module tb_if_id_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_ready;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_ready;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

`ifdef IF_ID_PERF_CNT_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    if_id_queue #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .f_valid    (f_valid),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .f_ready    (f_ready),
        .d_valid    (d_valid),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_ready    (d_ready),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; f_valid = 1'b0; f_pc = '0; f_instr = '0; d_ready = 1'b0;
        #3;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid got %0b want 0", d_valid); end
        checks++; if (f_ready !== 1'b1) begin errors++; $display("FAIL rst_f_ready got %0b want 1", f_ready); end
        checks++; if (d_pc !== 32'h0) begin errors++; $display("FAIL rst_d_pc got %h want 0", d_pc); end
        checks++; if (d_instr !== 32'h0) begin errors++; $display("FAIL rst_d_instr got %h want 0", d_instr); end
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
        checks++; if (bubble_cnt !== 32'h0) begin errors++; $display("FAIL rst_bubble got %0d want 0", bubble_cnt); end
        #9 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_order();
        f_valid = 1'b1; f_pc = 32'h100; f_instr = 32'hA0;
        tick();
        checks++; if (d_valid !== 1'b1 || d_pc !== 32'h100) begin errors++;
            $display("FAIL ord_lat1 got v=%0b pc=%h want v=1 pc=100", d_valid, d_pc); end
        f_pc = 32'h104; f_instr = 32'hA4;
        tick();
        checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL ord_full got %0b want 0", f_ready); end
        f_valid = 1'b0; d_ready = 1'b1;
        checks++; if (d_pc !== 32'h100 || d_instr !== 32'hA0) begin errors++;
            $display("FAIL ord_head0 got %h/%h want 100/a0", d_pc, d_instr); end
        tick();
        checks++; if (d_valid !== 1'b1 || d_pc !== 32'h104 || d_instr !== 32'hA4) begin errors++;
            $display("FAIL ord_head1 got v=%0b %h/%h want 1 104/a4", d_valid, d_pc, d_instr); end
        tick();
        d_ready = 1'b0;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL ord_empty got %0b want 0", d_valid); end
    endtask

    task automatic test_full_and_simul();
        f_valid = 1'b1; f_pc = 32'h200; f_instr = 32'hB0;
        tick();
        f_pc = 32'h204; f_instr = 32'hB4;
        tick();
        checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", f_ready); end
        f_pc = 32'h208; f_instr = 32'hB8;
        tick();
        tick();
        checks++; if (d_pc !== 32'h200 || d_valid !== 1'b1) begin errors++;
            $display("FAIL full_hold got v=%0b pc=%h want 1 200", d_valid, d_pc); end
        checks++; if (stall_cnt !== (PerfOn ? 32'd2 : 32'd0)) begin errors++;
            $display("FAIL full_stall got %0d want %0d", stall_cnt, PerfOn ? 2 : 0); end
        // Pop while full: push still blocked.
        d_ready = 1'b1;
        tick();
        checks++; if (f_ready !== 1'b1 || d_pc !== 32'h204) begin errors++;
            $display("FAIL full_pop got rdy=%0b pc=%h want 1 204", f_ready, d_pc); end
        // count=1: push 0x208 and pop 0x204 together.
        tick();
        checks++; if (d_valid !== 1'b1 || f_ready !== 1'b1 || d_pc !== 32'h208 || d_instr !== 32'hB8) begin
            errors++;
            $display("FAIL simul got v=%0b rdy=%0b %h/%h want 1 1 208/b8", d_valid, f_ready, d_pc, d_instr); end
        f_valid = 1'b0;
        tick();
        d_ready = 1'b0;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL simul_drain got %0b want 0", d_valid); end
        checks++; if (stall_cnt !== (PerfOn ? 32'd3 : 32'd0)) begin errors++;
            $display("FAIL full_stall3 got %0d want %0d", stall_cnt, PerfOn ? 3 : 0); end
    endtask

    task automatic test_no_bypass();
        f_valid = 1'b1; f_pc = 32'h300; f_instr = 32'hC0; d_ready = 1'b1;
        #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL bypass got %0b want 0", d_valid); end
        tick();
        f_valid = 1'b0; d_ready = 1'b0;
        checks++; if (d_valid !== 1'b1 || d_pc !== 32'h300) begin errors++;
            $display("FAIL nobyp_out got v=%0b pc=%h want 1 300", d_valid, d_pc); end
        checks++; if (bubble_cnt !== (PerfOn ? 32'd1 : 32'd0)) begin errors++;
            $display("FAIL bubble got %0d want %0d", bubble_cnt, PerfOn ? 1 : 0); end
    endtask

    task automatic test_flush();
        f_valid = 1'b1; f_pc = 32'h400; f_instr = 32'hD0;
        tick();
        flush = 1'b1; f_pc = 32'h404; f_instr = 32'hD4; d_ready = 1'b1;
        tick();
        flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
        checks++; if (d_valid !== 1'b0 || f_ready !== 1'b1) begin errors++;
            $display("FAIL flush got v=%0b rdy=%0b want 0 1", d_valid, f_ready); end
        f_valid = 1'b1; f_pc = 32'h500; f_instr = 32'hE0;
        tick();
        checks++; if (d_pc !== 32'h500 || d_instr !== 32'hE0) begin errors++;
            $display("FAIL flush_absent got %h/%h want 500/e0", d_pc, d_instr); end
        checks++; if (stall_cnt !== (PerfOn ? 32'd4 : 32'd0)) begin errors++;
            $display("FAIL flush_stall got %0d want %0d", stall_cnt, PerfOn ? 4 : 0); end
    endtask

    task automatic test_reset_mid();
        f_pc = 32'h504; f_instr = 32'hE4;
        tick();
        f_valid = 1'b0;
        checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL mid_pre got %0b want 0", f_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (d_valid !== 1'b0 || f_ready !== 1'b1 || d_pc !== 32'h0) begin errors++;
            $display("FAIL mid_rst got v=%0b rdy=%0b pc=%h want 0 1 0", d_valid, f_ready, d_pc); end
        checks++; if (stall_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin errors++;
            $display("FAIL mid_cnt got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
        #2 rst_n = 1'b1;
        f_valid = 1'b1; f_pc = 32'h600; f_instr = 32'hF0;
        tick();
        f_valid = 1'b0;
        checks++; if (d_valid !== 1'b1 || d_pc !== 32'h600 || f_ready !== 1'b1) begin errors++;
            $display("FAIL mid_after got v=%0b pc=%h rdy=%0b want 1 600 1", d_valid, d_pc, f_ready); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_and_simul();
        test_no_bypass();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
